// File: rtl/wrap_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// wrap_scheduler_pkg
// Shared types for the per-core wrap scheduler: default wrap count, the wrap
// identifier type and the per-wrap lifecycle state encoding.
// -----------------------------------------------------------------------------
package wrap_scheduler_pkg;

  localparam int NUM_WRAPS_PER_CORE = 4;
  localparam int WRAP_ID_W          = $clog2(NUM_WRAPS_PER_CORE);

  typedef logic [WRAP_ID_W-1:0] wrapId_t;

  // IDLE: not launched; READY: eligible for fetch;
  // STALL_T: timed stall (counter running); STALL_E: waiting for a wake event.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    STALL_T = 2'd2,
    STALL_E = 2'd3
  } wrap_state_t;

endpackage

// File: rtl/wrap_scheduler_if.sv
// -----------------------------------------------------------------------------
// wrap_scheduler_if
// Bundles the control (launch/halt), pipeline (stall/wake) and fetch-side
// signals of the wrap scheduler.
//   slave  : scheduler side (control inputs in, select/status out)
//   master : core/fetch side (drives control, observes select/status)
// -----------------------------------------------------------------------------
interface wrap_scheduler_if
  import wrap_scheduler_pkg::*;
#(
  parameter int NUM_WRAPS = NUM_WRAPS_PER_CORE,
  parameter int STALL_W   = 6
);

  localparam int ID_W = $clog2(NUM_WRAPS);

  logic                 launchValid;
  logic [NUM_WRAPS-1:0] launchMask;
  logic                 haltValid;
  logic [ID_W-1:0]      haltWrapId;
  logic                 stallValid;
  logic [ID_W-1:0]      stallWrapId;
  logic [STALL_W-1:0]   stallCycles;
  logic                 wakeValid;
  logic [ID_W-1:0]      wakeWrapId;
  logic                 fetchReady;
  logic                 selectValid;
  logic [NUM_WRAPS-1:0] selectedWrapOH;
  logic [ID_W-1:0]      selectedWrapId;
  logic [NUM_WRAPS-1:0] activeMask;
  logic                 idle;

  modport slave (
    input  launchValid, launchMask, haltValid, haltWrapId,
           stallValid, stallWrapId, stallCycles, wakeValid, wakeWrapId,
           fetchReady,
    output selectValid, selectedWrapOH, selectedWrapId, activeMask, idle
  );

  modport master (
    output launchValid, launchMask, haltValid, haltWrapId,
           stallValid, stallWrapId, stallCycles, wakeValid, wakeWrapId,
           fetchReady,
    input  selectValid, selectedWrapOH, selectedWrapId, activeMask, idle
  );

endinterface

// File: rtl/wrap_rr_picker.sv
// -----------------------------------------------------------------------------
// wrap_rr_picker
// Combinational rotating-priority picker. Searches the eligible mask starting
// at last_grant+1 and wrapping modulo NUM_WRAPS (NUM_WRAPS a power of two).
//   eligible   in  candidate mask
//   last_grant in  most recently accepted pick
//   pick_oh    out one-hot pick, zero when nothing eligible
//   pick_id    out binary pick, zero when nothing eligible
//   pick_valid out some candidate eligible
// -----------------------------------------------------------------------------
module wrap_rr_picker
  import wrap_scheduler_pkg::*;
#(
  parameter int NUM_WRAPS = NUM_WRAPS_PER_CORE,
  localparam int ID_W     = $clog2(NUM_WRAPS)
) (
  input  logic [NUM_WRAPS-1:0] eligible,
  input  logic [ID_W-1:0]      last_grant,
  output logic [NUM_WRAPS-1:0] pick_oh,
  output logic [ID_W-1:0]      pick_id,
  output logic                 pick_valid
);

  logic [ID_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_oh    = '0;
    pick_id    = '0;
    pick_valid = 1'b0;
    cand       = '0;
    // i == NUM_WRAPS truncates back to last_grant itself, so it is searched last.
    for (int i = 1; i <= NUM_WRAPS; i++) begin
      cand = last_grant + ID_W'(i);
      if (!pick_valid && eligible[cand]) begin
        pick_valid    = 1'b1;
        pick_id       = cand;
        pick_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrap_scheduler.sv
// -----------------------------------------------------------------------------
// wrap_scheduler
// Per-core wrap scheduler. Keeps a lifecycle state per wrap, forms the eligible
// (READY) mask and selects one wrap round-robin for fetch each cycle.
//   clk    in  core clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport: launch/halt, stall/wake, fetchReady in;
//          selectValid, selectedWrapOH, selectedWrapId, activeMask, idle out
// Select outputs depend on registered state only.
// -----------------------------------------------------------------------------
module wrap_scheduler
  import wrap_scheduler_pkg::*;
#(
  parameter int NUM_WRAPS = NUM_WRAPS_PER_CORE,
  parameter int STALL_W   = 6
) (
  input logic             clk,
  input logic             reset,
  wrap_scheduler_if.slave bus
);

  localparam int ID_W = $clog2(NUM_WRAPS);

  logic [NUM_WRAPS-1:0] eligible;
  logic [NUM_WRAPS-1:0] active;
  logic [ID_W-1:0]      last_grant;
  logic [NUM_WRAPS-1:0] pick_oh;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_valid;

  for (genvar w = 0; w < NUM_WRAPS; w++) begin : g_wrap
    wrap_state_t        state_q, state_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic               halt_hit, stall_hit, wake_hit, launch_hit;

    assign halt_hit   = bus.haltValid  && (bus.haltWrapId  == ID_W'(w));
    assign stall_hit  = bus.stallValid && (bus.stallWrapId == ID_W'(w));
    assign wake_hit   = bus.wakeValid  && (bus.wakeWrapId  == ID_W'(w));
    assign launch_hit = bus.launchValid && bus.launchMask[w];

    // Priority halt > stall > wake > launch. A stall on an IDLE wrap is
    // dropped, so a same-cycle launch of that wrap still takes effect.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (halt_hit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (stall_hit && (state_q != IDLE)) begin
        if (bus.stallCycles != '0) begin
          state_d = STALL_T;
          cnt_d   = bus.stallCycles;
        end else begin
          state_d = STALL_E;
          cnt_d   = '0;
        end
      end else if (wake_hit && (state_q == STALL_E)) begin
        state_d = READY;
      end else if (launch_hit && (state_q == IDLE)) begin
        state_d = READY;
      end else if (state_q == STALL_T) begin
        // Counter value N is held in the first stalled cycle, so the wrap
        // returns to READY exactly N cycles after the stall request.
        if (cnt_q == STALL_W'(1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - STALL_W'(1);
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign eligible[w] = (state_q == READY);
    assign active[w]   = (state_q != IDLE);
  end

  wrap_rr_picker #(.NUM_WRAPS(NUM_WRAPS)) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant),
    .pick_oh    (pick_oh),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  // Pointer only moves when fetch actually takes the pick, so a stalled fetch
  // sees a stable selection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= ID_W'(NUM_WRAPS - 1);
    end else if (pick_valid && bus.fetchReady) begin
      last_grant <= pick_id;
    end
  end

  assign bus.selectValid    = pick_valid;
  assign bus.selectedWrapOH = pick_oh;
  assign bus.selectedWrapId = pick_id;
  assign bus.activeMask     = active;
  assign bus.idle           = ~|active;

endmodule

// File: doc/wrap_scheduler.md
# wrap_scheduler

Per-core wrap scheduler that decides which wrap the fetch stage advances each cycle. Tracks a lifecycle state per wrap (idle, ready, timed stall, event wait), forms the eligible mask and picks one wrap round-robin. Sits between core control (launch/halt), the instruction-cache and pipeline (stall/wake) and fetch, which consumes the one-hot select and bumps that wrap's PC.

## Interface
- NUM_WRAPS, default NUM_WRAPS_PER_CORE (4): wraps per core; power of two, ≥2.
- STALL_W, default 6: width of stall cycle count.
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset; one clock, asynchronous active-low reset, no other clock/reset.
- launchValid  in  1  activate wraps in launchMask.
- launchMask  in  NUM_WRAPS  wraps to move IDLE→READY.
- haltValid  in  1  retire wrap haltWrapId.
- haltWrapId  in  $clog2(NUM_WRAPS)  wrap to halt.
- stallValid  in  1  stall wrap stallWrapId.
- stallWrapId  in  $clog2(NUM_WRAPS)  wrap to stall.
- stallCycles  in  STALL_W  0 = wait for wake; N>0 = timed stall.
- wakeValid  in  1  release event wait of wakeWrapId.
- wakeWrapId  in  $clog2(NUM_WRAPS)  wrap to wake.
- fetchReady  in  1  fetch accepts the current select.
- selectValid  out  1  some wrap eligible.
- selectedWrapOH  out  NUM_WRAPS  one-hot pick; all-zero when !selectValid.
- selectedWrapId  out  $clog2(NUM_WRAPS)  binary of pick; 0 when !selectValid.
- activeMask  out  NUM_WRAPS  wraps not IDLE.
- idle  out  1  all wraps IDLE.

## Operation
- Per-wrap states: IDLE, READY, STALL_T (counter), STALL_E (event). Eligible = READY.
- IDLE→READY: launchValid and launchMask bit set. Launch of a non-IDLE wrap ignored.
- any non-IDLE→IDLE: haltValid for that wrap; counter cleared.
- READY→STALL_T: stallValid, stallCycles=N>0; counter loads N.
- READY→STALL_E: stallValid, stallCycles=0.
- STALL_T: counter decrements each cycle; at counter==1 next state READY. Stall on a stalled wrap reloads/overrides (latest stall wins). Stall on IDLE wrap ignored.
- STALL_E→READY: wakeValid for that wrap. Wake of any other state ignored.
- Same-wrap same-cycle priority: halt > stall > wake > launch. Different wraps: all apply independently.
- Round-robin: registered pointer lastGrant (reset to wrap NUM_WRAPS-1). Pick first eligible wrap searching from lastGrant+1 upward, wrapping modulo NUM_WRAPS. lastGrant updates to the pick only when selectValid && fetchReady.
- selectValid = |eligible. Select outputs combinational from registered state only (no input→output path).
- A grant accepted in the same cycle a stall targets that wrap: grant still counts (fetch advanced); stall applies next cycle.

## Timing
- Reset (reset low, async): all wraps IDLE, counters 0, lastGrant = NUM_WRAPS-1; outputs selectValid=0, selectedWrapOH=0, selectedWrapId=0, activeMask=0, idle=1.
- Launch in cycle t → eligible, selectable in t+1.
- Stall in t with N → wrap ineligible in cycles t+1..t+N, eligible again t+N+1.
- Wake in t → eligible in t+1.
- Halt in t → activeMask bit clear in t+1.
- fetchReady low: select held stable while eligible set unchanged; pointer frozen.
- Single ready wrap granted every cycle fetchReady is high (no bubble).
- Reset asserted mid-stall: immediate return to reset values; no residual counters.

## Structure
- Package defines: NUM_WRAPS_PER_CORE, wrapId_t, wrap_state_t enum (IDLE, READY, STALL_T, STALL_E).
- Sub-module wrap_rr_picker: combinational rotate-priority pick (eligible mask, lastGrant → one-hot + binary + valid), reusable elsewhere.
- Per-wrap state/counter in a generate loop.

## Test plan
- Reset then launchMask=4'b1111, fetchReady=1 → grants wrap 0,1,2,3,0… one per cycle starting cycle after launch.
- Wraps 0–3 ready, stall wrap 1 with stallCycles=3 at t → wrap 1 absent from grants t+1..t+3, present again from t+4 in rotation order.
- Stall wrap 2 with stallCycles=0, wake at t+10 → wrap 2 never granted t+1..t+10, granted again ≥t+11.
- fetchReady=0 for 5 cycles with wraps 0,2 ready → selectedWrapOH holds 4'b0001 (or current pick), lastGrant unchanged; resumes rotation on release.
- Same cycle: halt and wake wrap 3 in STALL_E → wrap 3 IDLE; launch+stall same wrap → stall ignored... wrap ends READY only if launched IDLE, stall dropped; halt all → idle=1, selectValid=0 next cycle.
- Assert reset mid STALL_T (counter=5) → outputs at reset values immediately; after release, relaunch wrap → eligible next cycle, no stall.
